kamikaze_hazard_ctrl: RTL and testbench
=======================================

Name: kamikaze_hazard_ctrl

Overview:
Pipeline hazard and flush controller for the kamikaze in-order core. It sits beside the decode stage and gates hand-off of each decoded instruction into execute. It keeps a register scoreboard of outstanding writers (multi-cycle loads and ALU results not yet written back), stalls on RAW and WAW hazards and on a full scoreboard, and sequences the fetch/decode flush after a taken branch or jump.

Parameters:
- MAX_PENDING, 4, maximum number of outstanding register writers (1..31).
- FLUSH_CYCLES, 2, number of cycles flush_o stays asserted after a redirect (1..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- dec_valid_i  in  1  decode stage holds a valid instruction.
- dec_rs1_i  in  5  source register 1 address.
- dec_rs2_i  in  5  source register 2 address.
- dec_rd_i  in  5  destination register address.
- dec_uses_rs1_i  in  1  instruction reads rs1.
- dec_uses_rs2_i  in  1  instruction reads rs2.
- dec_writes_rd_i  in  1  instruction writes rd.
- wb_valid_i  in  1  writeback retires a register write this cycle.
- wb_rd_i  in  5  writeback destination.
- redirect_i  in  1  execute resolved a taken branch/jump (single-cycle pulse).
- issue_o  out  1  combinational; the decoded instruction moves to execute this cycle.
- stall_o  out  1  combinational; fetch/decode hold their contents.
- flush_o  out  1  registered; fetch/decode invalidate their contents.
- pending_cnt_o  out  3  number of outstanding writers (width is clog2(MAX_PENDING+1)).
- spurious_wb_o  out  1  registered one-cycle pulse on a writeback to a non-pending register.

Behaviour:
- Reset values: pending vector 0, count 0, state RUN, flush_o 0, spurious_wb_o 0. issue_o and stall_o are 0 while reset is held.
- FSM states:
  - RUN to FLUSH on redirect_i; flush_o goes 1 from the next edge and the flush counter loads FLUSH_CYCLES-1.
  - FLUSH decrements the counter each cycle and returns to RUN when it reaches 0. flush_o is therefore high for exactly FLUSH_CYCLES cycles.
  - redirect_i during FLUSH reloads the counter.
- Hazard terms, each qualified by dec_valid_i:
  - raw = (uses_rs1 & pend[rs1]) | (uses_rs2 & pend[rs2]).
  - waw = writes_rd & pend[rd].
  - full = writes_rd & (rd != 0) & (count == MAX_PENDING).
- Register x0 is never pending; reads and writes of x0 never cause hazards.
- Outputs:
  - stall_o = dec_valid_i & (raw | waw | full) & state==RUN & !redirect_i.
  - issue_o = dec_valid_i & !stall_o & state==RUN & !redirect_i.
  - No issue occurs in FLUSH or in the cycle redirect_i is high.
- Scoreboard update at the clock edge:
  - set(rd) when issue_o & writes_rd & rd != 0.
  - clear(wb_rd) when wb_valid_i & pend[wb_rd].
  - Same register set and cleared in the same cycle: set wins (the bit stays 1).
  - count: +1 on set only, -1 on clear only, unchanged on both. The count never exceeds MAX_PENDING.
- wb_valid_i to a non-pending register, or to x0: no state change, and spurious_wb_o pulses on the next edge.
- redirect_i does not clear the scoreboard, because writers already in execute still retire.
- Reset asserted mid-operation returns all state to reset values immediately.

Optional Feature:
- Macro KAMIKAZE_WB_BYPASS_EN.
- Defined: a register being cleared by writeback this cycle counts as not pending when evaluating raw and waw, so there is zero-cycle hazard release; the register file must forward the write data.
- Undefined: hazards use the registered pending vector only, and the consumer stalls one extra cycle after writeback.

Decomposition:
- kamikaze_pkg holds:
  - REG_ADDR_W=5 and NUM_REGS=32.
  - FSM state encodings ST_RUN and ST_FLUSH.
  - A function for the count width.
- One sub-module, kamikaze_scoreboard, holds the pending vector, count, set/clear arbitration and the spurious-writeback detection.
- The FSM and the hazard equations stay in the top module.

Test Plan:
- RAW: issue rd=5 (writes); next cycle decode rs1=5 with uses_rs1 -> stall_o=1 and issue_o=0 until wb_rd=5. Release on the wb cycle with bypass, or the cycle after without it.
- x0: issue rd=0 writes_rd, then read rs1=0 -> no stall, pending_cnt_o stays 0, no spurious pulse on wb_rd=0 from a set.
- Full: MAX_PENDING=4; issue writers rd=1,2,3,4; 5th writer rd=6 -> stall_o=1 and count=4. wb_rd=1 -> issue next cycle and count returns to 4.
- Simultaneous set/clear: pending rd=7; wb_rd=7 in the same cycle a new writer rd=7 issues (bypass build) -> pend[7] stays 1 and count unchanged.
- Flush: redirect_i pulse -> flush_o high exactly 2 cycles with issue_o=0 throughout. A second redirect in the first flush cycle extends flush_o to 3 cycles total.
- Spurious wb: wb_valid_i with wb_rd=9 not pending -> spurious_wb_o=1 for one cycle, count unchanged. Assert rst_i low mid-flush -> flush_o=0 and count=0 immediately.

Source files
------------

// File: rtl/kamikaze_pkg.sv
// Shared constants, FSM encoding and width helper for the kamikaze hazard controller.
// Build option KAMIKAZE_WB_BYPASS_EN is consumed by kamikaze_scoreboard.
package kamikaze_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic int cnt_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/kamikaze_scoreboard.sv
// Register scoreboard: pending-writer vector, writer count and spurious-writeback pulse.
// KAMIKAZE_WB_BYPASS_EN: the register retiring this cycle is hidden from the hazard view.
module kamikaze_scoreboard
    import kamikaze_pkg::*;
#(
    parameter  int MAX_PENDING = 4,
    localparam int CNT_W       = cnt_width(MAX_PENDING)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  set_i,
    input  logic [REG_ADDR_W-1:0] set_rd_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    output logic [NUM_REGS-1:0]   hz_pend_o,
    output logic [CNT_W-1:0]      cnt_o,
    output logic                  spurious_o
);

    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [NUM_REGS-1:0] set_vec, clr_vec;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                spurious_q, spurious_d;
    logic                clr_hit;
    logic                set_eff;

    assign clr_hit = wb_valid_i & pend_q[wb_rd_i];

    // x0 is hard-wired out of the set decode so it can never become pending.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        if (gi == 0) begin : g_x0
            assign set_vec[gi] = 1'b0;
        end else begin : g_rn
            assign set_vec[gi] = set_i & (set_rd_i == REG_ADDR_W'(gi));
        end
        assign clr_vec[gi] = clr_hit & (wb_rd_i == REG_ADDR_W'(gi));
    end

    assign set_eff = |set_vec;

    always_comb begin
        pend_d     = (pend_q & ~clr_vec) | set_vec;
        cnt_d      = cnt_q;
        spurious_d = wb_valid_i & ~pend_q[wb_rd_i];
        case ({set_eff, clr_hit})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_q     <= '0;
            cnt_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            spurious_q <= spurious_d;
        end
    end

`ifdef KAMIKAZE_WB_BYPASS_EN
    assign hz_pend_o = pend_q & ~clr_vec;
`else
    assign hz_pend_o = pend_q;
`endif

    assign cnt_o      = cnt_q;
    assign spurious_o = spurious_q;

endmodule

// File: rtl/kamikaze_hazard_ctrl.sv
// Decode-to-execute gate: RAW/WAW/full-scoreboard stalls plus post-redirect flush sequencing.
// KAMIKAZE_WB_BYPASS_EN selects zero-cycle hazard release on writeback (see scoreboard).
module kamikaze_hazard_ctrl
    import kamikaze_pkg::*;
#(
    parameter  int MAX_PENDING  = 4,
    parameter  int FLUSH_CYCLES = 2,
    localparam int CNT_W        = cnt_width(MAX_PENDING)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dec_valid_i,
    input  logic [REG_ADDR_W-1:0] dec_rs1_i,
    input  logic [REG_ADDR_W-1:0] dec_rs2_i,
    input  logic [REG_ADDR_W-1:0] dec_rd_i,
    input  logic                  dec_uses_rs1_i,
    input  logic                  dec_uses_rs2_i,
    input  logic                  dec_writes_rd_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  redirect_i,
    output logic                  issue_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [CNT_W-1:0]      pending_cnt_o,
    output logic                  spurious_wb_o
);

    localparam int            FLUSH_W = 4;
    localparam [FLUSH_W-1:0]  RELOAD  = FLUSH_W'(FLUSH_CYCLES - 1);

    state_e               state_q, state_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                 flush_q, flush_d;

    logic [NUM_REGS-1:0]  hz_pend;
    logic [CNT_W-1:0]     cnt;
    logic                 raw, waw, full, run;

    kamikaze_scoreboard #(
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (issue_o & dec_writes_rd_i),
        .set_rd_i   (dec_rd_i),
        .wb_valid_i (wb_valid_i),
        .wb_rd_i    (wb_rd_i),
        .hz_pend_o  (hz_pend),
        .cnt_o      (cnt),
        .spurious_o (spurious_wb_o)
    );

    assign run  = (state_q == ST_RUN);
    assign raw  = (dec_uses_rs1_i & hz_pend[dec_rs1_i]) | (dec_uses_rs2_i & hz_pend[dec_rs2_i]);
    assign waw  = dec_writes_rd_i & hz_pend[dec_rd_i];
    assign full = dec_writes_rd_i & (dec_rd_i != '0) & (cnt == CNT_W'(MAX_PENDING));

    // Gated by rst_i so nothing is handed to execute while reset is held.
    assign stall_o = rst_i & dec_valid_i & (raw | waw | full) & run & ~redirect_i;
    assign issue_o = rst_i & dec_valid_i & ~stall_o & run & ~redirect_i;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        flush_d     = flush_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_i) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = RELOAD;
                    flush_d     = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (redirect_i) begin
                    flush_cnt_d = RELOAD;
                    flush_d     = 1'b1;
                end else if (flush_cnt_q == '0) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            flush_q     <= flush_d;
        end
    end

    assign flush_o       = flush_q;
    assign pending_cnt_o = cnt;

endmodule

// File: tb/tb_kamikaze_hazard_ctrl.sv
// Randomised plus directed scoreboard bench for kamikaze_hazard_ctrl against a set-based reference model.
module tb_kamikaze_hazard_ctrl;

    localparam int MAXP = 4;
    localparam int FLC  = 2;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       dec_valid_i = 1'b0;
    logic [4:0] dec_rs1_i = '0, dec_rs2_i = '0, dec_rd_i = '0, wb_rd_i = '0;
    logic       dec_uses_rs1_i = 1'b0, dec_uses_rs2_i = 1'b0, dec_writes_rd_i = 1'b0;
    logic       wb_valid_i = 1'b0, redirect_i = 1'b0;
    logic       issue_o, stall_o, flush_o, spurious_wb_o;
    logic [2:0] pending_cnt_o;

    kamikaze_hazard_ctrl #(.MAX_PENDING(MAXP), .FLUSH_CYCLES(FLC)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .dec_valid_i     (dec_valid_i),
        .dec_rs1_i       (dec_rs1_i),
        .dec_rs2_i       (dec_rs2_i),
        .dec_rd_i        (dec_rd_i),
        .dec_uses_rs1_i  (dec_uses_rs1_i),
        .dec_uses_rs2_i  (dec_uses_rs2_i),
        .dec_writes_rd_i (dec_writes_rd_i),
        .wb_valid_i      (wb_valid_i),
        .wb_rd_i         (wb_rd_i),
        .redirect_i      (redirect_i),
        .issue_o         (issue_o),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .pending_cnt_o   (pending_cnt_o),
        .spurious_wb_o   (spurious_wb_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit issue;
        bit stall;
        bit flush;
        int cnt;
        bit spur;
        int id;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   txn = 0;

    // Reference model: set of pending registers, remaining flush cycles, pending spurious pulse.
    bit   m_pend[32];
    int   m_rem = 0;
    bit   m_spur = 0;

    function automatic int m_cnt();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_pend[r]);
        return c;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        m_rem  = 0;
        m_spur = 1'b0;
    endtask

    task automatic idle_inputs();
        dec_valid_i = 0; dec_uses_rs1_i = 0; dec_uses_rs2_i = 0; dec_writes_rd_i = 0;
        wb_valid_i = 0; redirect_i = 0;
        dec_rs1_i = '0; dec_rs2_i = '0; dec_rd_i = '0; wb_rd_i = '0;
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                         input bit u1, input bit u2, input bit wr,
                         input bit wbv, input int wbrd, input bit redir);
        bit   hz[32];
        bit   running;
        bit   hazard;
        exp_t e;
        @(posedge clk);
        #1;
        dec_valid_i = v; dec_rs1_i = 5'(rs1); dec_rs2_i = 5'(rs2); dec_rd_i = 5'(rd);
        dec_uses_rs1_i = u1; dec_uses_rs2_i = u2; dec_writes_rd_i = wr;
        wb_valid_i = wbv; wb_rd_i = 5'(wbrd); redirect_i = redir;

        for (int r = 0; r < 32; r++) hz[r] = m_pend[r];
`ifdef KAMIKAZE_WB_BYPASS_EN
        if (wbv) hz[wbrd] = 1'b0;
`endif
        running = (m_rem == 0);
        hazard  = (u1 && hz[rs1]) || (u2 && hz[rs2]) || (wr && hz[rd]) ||
                  (wr && rd != 0 && m_cnt() == MAXP);
        e.stall = v && hazard && running && !redir;
        e.issue = v && !e.stall && running && !redir;
        e.flush = (m_rem > 0);
        e.cnt   = m_cnt();
        e.spur  = m_spur;
        e.id    = txn++;
        q.push_back(e);

        m_spur = wbv && !m_pend[wbrd];
        if (wbv && m_pend[wbrd]) m_pend[wbrd] = 1'b0;
        if (e.issue && wr && rd != 0) m_pend[rd] = 1'b1;
        m_rem = redir ? FLC : ((m_rem > 0) ? m_rem - 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int r = 1; r < 32; r++)
            if (m_pend[r]) drive(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
        idle(FLC + 2);
    endtask

    // Monitor: one expected record per cycle, compared half a period after the drive point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("issue", int'(issue_o), int'(e.issue));
                check("stall", int'(stall_o), int'(e.stall));
                check("flush", int'(flush_o), int'(e.flush));
                check("pending_cnt", int'(pending_cnt_o), e.cnt);
                check("spurious_wb", int'(spurious_wb_o), int'(e.spur));
                $display("txn %0d issue=%0b stall=%0b flush=%0b cnt=%0d spur=%0b",
                         e.id, issue_o, stall_o, flush_o, pending_cnt_o, spurious_wb_o);
            end
        end
    end

    initial begin
        int pend_list[$];
        int wbrd;
        model_reset();

        // Reset held with a valid writer on decode: nothing may issue or stall.
        dec_valid_i = 1; dec_writes_rd_i = 1; dec_rd_i = 5'd3;
        #12;
        check("rst_issue", int'(issue_o), 0);
        check("rst_stall", int'(stall_o), 0);
        check("rst_flush", int'(flush_o), 0);
        check("rst_cnt", int'(pending_cnt_o), 0);
        check("rst_spur", int'(spurious_wb_o), 0);
        idle_inputs();
        @(posedge clk); #1;
        rst_i = 1;

        // Randomised traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            pend_list.delete();
            for (int r = 1; r < 8; r++) if (m_pend[r]) pend_list.push_back(r);
            if (pend_list.size() > 0 && $urandom_range(9) < 8)
                wbrd = pend_list[$urandom_range(pend_list.size() - 1)];
            else
                wbrd = int'($urandom_range(9));
            drive($urandom_range(3) != 0,
                  int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(7)),
                  $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(3) != 0,
                  $urandom_range(9) < 4, wbrd, $urandom_range(19) == 0);
        end
        drain();

        // RAW on x5, released by its writeback.
        drive(1, 0, 0, 5, 0, 0, 1, 0, 0, 0);
        drive(1, 5, 0, 8, 1, 0, 0, 0, 0, 0);
        drive(1, 5, 0, 8, 1, 0, 0, 0, 0, 0);
        drive(1, 5, 0, 8, 1, 0, 0, 1, 5, 0);
        drive(1, 5, 0, 8, 1, 0, 0, 0, 0, 0);
        idle(1);

        // x0 is never pending; writeback to x0 is spurious.
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Full scoreboard: four writers then a fifth stalls until one retires.
        for (int r = 1; r <= 4; r++) drive(1, 0, 0, r, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 6, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 6, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 6, 0, 0, 1, 1, 1, 0);
        drive(1, 0, 0, 6, 0, 0, 1, 0, 0, 0);
        idle(1);
        drain();

        // New writer to x7 while x7 retires in the same cycle.
        drive(1, 0, 0, 7, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 7, 0, 0, 1, 1, 7, 0);
        drive(1, 0, 0, 7, 0, 0, 1, 0, 0, 0);
        idle(2);
        drain();

        // Single redirect, then a second redirect during the first flush cycle.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Spurious writeback to a non-pending register.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        idle(2);

        // Reset dropped mid-flush with writers outstanding.
        drive(1, 0, 0, 2, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 3, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 4, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        check("pre_rst_flush", int'(flush_o), int'(m_rem > 0));
        check("pre_rst_cnt", int'(pending_cnt_o), m_cnt());
        rst_i = 0;
        #1;
        check("mid_rst_flush", int'(flush_o), 0);
        check("mid_rst_cnt", int'(pending_cnt_o), 0);
        check("mid_rst_issue", int'(issue_o), 0);
        model_reset();
        idle_inputs();
        @(posedge clk); #1;
        rst_i = 1;
        drive(1, 2, 0, 2, 1, 0, 1, 0, 0, 0);
        drive(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);

        @(negedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
